serial_frame_rx: RTL

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_pkg.sv | 9 +
 rtl/serial_frame_rx.sv | 97 +++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state type and line-level constants for the serial frame receiver
package serial_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: strobed serial frame receiver (start, data, optional even parity, stop) with a one-word valid/ready output
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             sclr,
    input  logic             bit_en,
    input  logic             sdata,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_acc, par_mis, commit, bad_stop, last_bit;

    assign last_bit = cnt == CW'(WIDTH - 1);
    assign busy     = state != IDLE;

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        bad_stop  = 1'b0;
        if (bit_en)
            case (state)
                IDLE:    state_nxt = sdata == START_BIT ? DATA : IDLE;
                DATA:    state_nxt = last_bit ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
                PARITY:  state_nxt = STOP;
                default: begin
                    state_nxt = IDLE;
                    commit    = sdata == STOP_BIT;
                    bad_stop  = sdata != STOP_BIT;
                end
            endcase
        if (sclr) begin
            state_nxt = IDLE;
            commit    = 1'b0;
            bad_stop  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge aclr)
        if (aclr) state <= IDLE;
        else      state <= state_nxt;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cnt        <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            par_mis    <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (sclr) begin
                cnt       <= '0;
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if (bit_en && state == IDLE) par_acc <= 1'b0;
                if (bit_en && state == DATA) begin
                    shreg   <= MSB_FIRST != 0 ? {shreg[WIDTH-2:0], sdata} : {sdata, shreg[WIDTH-1:1]};
                    par_acc <= par_acc ^ sdata;
                    cnt     <= last_bit ? '0 : cnt + 1'b1;
                end
                if (bit_en && state == PARITY) par_mis <= par_acc != sdata;
                // A blocked commit keeps the held word; a transfer in the same cycle frees the slot
                if (commit && (!out_valid || out_ready)) begin
                    out_data   <= shreg;
                    parity_err <= PARITY_EN != 0 && par_mis;
                    out_valid  <= 1'b1;
                end else begin
                    if (commit) overrun <= 1'b1;
                    if (out_ready) out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
